// File: rtl/sram_sp_bwe_init.sv
// rtl/sram_sp_bwe_init.sv - single-port SRAM model with byte-group write mask, zero-init sweep and sticky error
module sram_sp_bwe_init #(
  parameter int Bits       = 64,
  parameter int Word_Depth = 512,
  parameter int Add_Width  = 9,
  parameter int Mask_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [Add_Width-1:0]  A,
  input  logic [Bits-1:0]       D,
  input  logic [Mask_Width-1:0] BWEB,
  output logic [Bits-1:0]       Q,
  output logic                  RDY,
  output logic                  ERR
);

  localparam int                   G     = Bits / Mask_Width;
  localparam logic [Add_Width-1:0] LAST  = Add_Width'(Word_Depth - 1);
  localparam logic [Add_Width:0]   DEPTH = (Add_Width + 1)'(Word_Depth);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [Add_Width-1:0] r_cnt, w_cnt_nxt;
  logic [Bits-1:0]      r_q, w_q_nxt;
  logic                 r_err, w_err_nxt;
  logic [Bits-1:0]      r_mem [Word_Depth];

  logic w_oob, w_sweep, w_rd, w_wr;

  assign w_oob   = ({1'b0, A} >= DEPTH);
  assign w_sweep = (r_state == INIT) && RSTB;
  assign w_rd    = (r_state == READY) && !CEB && WEB;
  assign w_wr    = (r_state == READY) && !CEB && !WEB && !w_oob;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_q     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_err_nxt   = r_err;
    case (r_state)
      INIT: begin
        // Any user access before the sweep completes is ignored but flagged.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST) w_state_nxt = READY;
        if (!CEB) w_err_nxt = 1'b1;
      end
      READY: begin
        if (!CEB && w_oob) w_err_nxt = 1'b1;
        if (w_rd) w_q_nxt = w_oob ? '0 : r_mem[A];
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // Array has no reset: only the sweep or a user write changes it.
  always_ff @(posedge CLK) begin
    if (w_sweep) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int g = 0; g < Mask_Width; g++) begin
        if (!BWEB[g]) r_mem[A][g*G +: G] <= D[g*G +: G];
      end
    end
  end

  assign Q   = r_q;
  assign RDY = (r_state == READY);
  assign ERR = r_err;

endmodule
